hilo_muldiv_ctrl: RTL and testbench

HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 40 ++++
 rtl/muldiv_iter_core.sv | 37 +++
 rtl/hilo_muldiv_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide controller.
// MULDIV_MADD_EN (optional) enables MADD/MSUB in hilo_muldiv_ctrl.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [5:0] ITER_COUNT = 6'd32;
    localparam logic [4:0] LAST_ITER  = 5'(ITER_COUNT - 6'd1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    function automatic logic isSignedOp(input logic [2:0] op);
        case (op)
            OP_MULT, OP_DIV, OP_MADD, OP_MSUB: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // Magnitude of a two's-complement value; 32'h80000000 maps to itself as unsigned.
    function automatic logic [31:0] absVal(input logic [31:0] v, input logic isSigned);
        if (isSigned && v[31]) begin
            return ~v + 32'd1;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 step: shift-add multiply or restoring shift-subtract divide,
// operating on the {accHi, accLo} working pair.
module muldiv_iter_core
    import muldiv_pkg::*;
(
    input  logic            isDiv,
    input  logic [XLEN-1:0] accHi,
    input  logic [XLEN-1:0] accLo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] nextHi,
    output logic [XLEN-1:0] nextLo
);

    logic [32:0] sum_s;
    logic [32:0] shifted_s;
    logic [33:0] diff_s;

    // For division accLo holds the dividend shifting out and the quotient shifting in.
    always_comb begin
        sum_s     = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : 33'd0);
        shifted_s = {accHi, accLo[31]};
        diff_s    = {1'b0, shifted_s} - {2'b00, operand};
        if (isDiv) begin
            if (!diff_s[33]) begin
                nextHi = diff_s[31:0];
                nextLo = {accLo[30:0], 1'b1};
            end else begin
                nextHi = shifted_s[31:0];
                nextLo = {accLo[30:0], 1'b0};
            end
        end else begin
            nextHi = sum_s[32:1];
            nextLo = {sum_s[0], accLo[31:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide controller: FSM, sign fix-up and architectural HI/LO.
// Define MULDIV_MADD_EN to run MADD/MSUB; otherwise those opcodes are no-ops.
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        ReadHiLo,
    input  logic        Flush,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Stall,
    output logic        Done,
    output logic        DivZero
);

    logic [1:0]  state_r,    stateNext_s;
    logic [4:0]  iterCnt_r,  cntNext_s;
    logic [2:0]  op_r,       opNext_s;
    logic        signA_r,    signANext_s;
    logic        signB_r,    signBNext_s;
    logic [31:0] operand_r,  operandNext_s;
    logic [31:0] aSave_r,    aSaveNext_s;
    logic [31:0] workHi_r,   workHiNext_s;
    logic [31:0] workLo_r,   workLoNext_s;
    logic [31:0] hi_r,       hiNext_s;
    logic [31:0] lo_r,       loNext_s;
    logic        done_r,     doneNext_s;
    logic        divZero_r,  divZeroNext_s;

    logic [31:0] magA_s, magB_s, stepHi_s, stepLo_s, quo_s, rem_s;
    logic [63:0] prod_s, fixHiLo_s;
    logic        isDivOp_s, fixDivZero_s;

    muldiv_iter_core uIterCore (
        .isDiv   (state_r == ST_DIV),
        .accHi   (workHi_r),
        .accLo   (workLo_r),
        .operand (operand_r),
        .nextHi  (stepHi_s),
        .nextLo  (stepLo_s)
    );

    // Sign fix-up of the raw magnitudes and selection of the value written to HI/LO.
    always_comb begin
        isDivOp_s = (op_r == OP_DIV) || (op_r == OP_DIVU);
        if (isSignedOp(op_r) && (signA_r ^ signB_r)) begin
            prod_s = ~{workHi_r, workLo_r} + 64'd1;
            quo_s  = ~workLo_r + 32'd1;
        end else begin
            prod_s = {workHi_r, workLo_r};
            quo_s  = workLo_r;
        end
        if (isSignedOp(op_r) && signA_r) begin
            rem_s = ~workHi_r + 32'd1;
        end else begin
            rem_s = workHi_r;
        end
        fixDivZero_s = isDivOp_s && (operand_r == 32'd0);
        case (op_r)
            OP_DIV, OP_DIVU: begin
                if (fixDivZero_s) begin
                    fixHiLo_s = {aSave_r, 32'hFFFF_FFFF};
                end else begin
                    fixHiLo_s = {rem_s, quo_s};
                end
            end
`ifdef MULDIV_MADD_EN
            OP_MADD: fixHiLo_s = {hi_r, lo_r} + prod_s;
            OP_MSUB: fixHiLo_s = {hi_r, lo_r} - prod_s;
`endif
            default: fixHiLo_s = prod_s;
        endcase
    end

    // Next-state logic: accept only from IDLE, Flush aborts any busy state.
    always_comb begin
        stateNext_s   = state_r;
        cntNext_s     = iterCnt_r;
        opNext_s      = op_r;
        signANext_s   = signA_r;
        signBNext_s   = signB_r;
        operandNext_s = operand_r;
        aSaveNext_s   = aSave_r;
        workHiNext_s  = workHi_r;
        workLoNext_s  = workLo_r;
        hiNext_s      = hi_r;
        loNext_s      = lo_r;
        doneNext_s    = 1'b0;
        divZeroNext_s = 1'b0;
        magA_s        = absVal(A, isSignedOp(Op));
        magB_s        = absVal(B, isSignedOp(Op));
        case (state_r)
            ST_IDLE: begin
                if (Start && !Flush) begin
                    opNext_s    = Op;
                    signANext_s = A[31];
                    signBNext_s = B[31];
                    aSaveNext_s = A;
                    cntNext_s   = 5'd0;
                    case (Op)
                        OP_MULT, OP_MULTU: begin
                            stateNext_s   = ST_MUL;
                            workHiNext_s  = 32'd0;
                            workLoNext_s  = magB_s;
                            operandNext_s = magA_s;
                        end
`ifdef MULDIV_MADD_EN
                        OP_MADD, OP_MSUB: begin
                            stateNext_s   = ST_MUL;
                            workHiNext_s  = 32'd0;
                            workLoNext_s  = magB_s;
                            operandNext_s = magA_s;
                        end
`endif
                        OP_DIV, OP_DIVU: begin
                            stateNext_s   = ST_DIV;
                            workHiNext_s  = 32'd0;
                            workLoNext_s  = magA_s;
                            operandNext_s = magB_s;
                        end
                        OP_MTHI: hiNext_s = A;
                        OP_MTLO: loNext_s = A;
                        default: stateNext_s = ST_IDLE;
                    endcase
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (Flush) begin
                    stateNext_s = ST_IDLE;
                    cntNext_s   = 5'd0;
                end else begin
                    workHiNext_s = stepHi_s;
                    workLoNext_s = stepLo_s;
                    cntNext_s    = iterCnt_r + 5'd1;
                    if (iterCnt_r == LAST_ITER) begin
                        stateNext_s = ST_FIX;
                    end else begin
                        stateNext_s = state_r;
                    end
                end
            end
            ST_FIX: begin
                stateNext_s = ST_IDLE;
                cntNext_s   = 5'd0;
                if (!Flush) begin
                    hiNext_s      = fixHiLo_s[63:32];
                    loNext_s      = fixHiLo_s[31:0];
                    doneNext_s    = 1'b1;
                    divZeroNext_s = fixDivZero_s;
                end else begin
                    doneNext_s = 1'b0;
                end
            end
            default: begin
                stateNext_s = ST_IDLE;
                cntNext_s   = 5'd0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by Reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r   <= ST_IDLE;
            iterCnt_r <= 5'd0;
            op_r      <= 3'd0;
            signA_r   <= 1'b0;
            signB_r   <= 1'b0;
            operand_r <= 32'd0;
            aSave_r   <= 32'd0;
            workHi_r  <= 32'd0;
            workLo_r  <= 32'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            done_r    <= 1'b0;
            divZero_r <= 1'b0;
        end else begin
            state_r   <= stateNext_s;
            iterCnt_r <= cntNext_s;
            op_r      <= opNext_s;
            signA_r   <= signANext_s;
            signB_r   <= signBNext_s;
            operand_r <= operandNext_s;
            aSave_r   <= aSaveNext_s;
            workHi_r  <= workHiNext_s;
            workLo_r  <= workLoNext_s;
            hi_r      <= hiNext_s;
            lo_r      <= loNext_s;
            done_r    <= doneNext_s;
            divZero_r <= divZeroNext_s;
        end
    end

    assign HI      = hi_r;
    assign LO      = lo_r;
    assign Busy    = (state_r != ST_IDLE);
    assign Stall   = Busy & (Start | ReadHiLo);
    assign Done    = done_r;
    assign DivZero = divZero_r;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: arithmetic reference model plus
// directed vectors; MADD/MSUB expectations follow MULDIV_MADD_EN.
module tb_hilo_muldiv_ctrl;
    import muldiv_pkg::*;

`ifdef MULDIV_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        ReadHiLo = 1'b0;
    logic        Flush = 1'b0;
    logic [31:0] HI, LO;
    logic        Busy, Stall, Done, DivZero;

    hilo_muldiv_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .ReadHiLo(ReadHiLo), .Flush(Flush), .HI(HI), .LO(LO), .Busy(Busy),
        .Stall(Stall), .Done(Done), .DivZero(DivZero)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    bit checkEn = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {divZero, HI, LO} for an operation.
    function automatic logic [64:0] modelOp(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] ua, ub, res;
        logic dz;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        case (op)
            3'b000: res = sa * sb;
            3'b001: res = ua * ub;
            3'b010: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF}; dz = 1'b1;
                end else begin
                    q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]};
                end
            end
            3'b011: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF}; dz = 1'b1;
                end else begin
                    res = {a % b, a / b};
                end
            end
            3'b110: res = {hi, lo} + 64'(sa * sb);
            3'b111: res = {hi, lo} - 64'(sa * sb);
            default: res = {hi, lo};
        endcase
        return {dz, res};
    endfunction

    logic [31:0] mHi = 32'd0, mLo = 32'd0, pHi = 32'd0, pLo = 32'd0;
    logic        mDone = 1'b0, mDz = 1'b0, pDz = 1'b0;
    int          mLeft = 0;

    // Model: one countdown of 33 edges per multi-cycle op, results committed when it expires.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mHi = 32'd0; mLo = 32'd0; mLeft = 0; mDone = 1'b0; mDz = 1'b0;
        end else begin
            mDone = 1'b0; mDz = 1'b0;
            if (mLeft > 0) begin
                if (Flush) begin
                    mLeft = 0;
                end else begin
                    mLeft--;
                    if (mLeft == 0) begin
                        mHi = pHi; mLo = pLo; mDone = 1'b1; mDz = pDz;
                    end
                end
            end else if (Start && !Flush) begin
                if (Op == OP_MTHI) mHi = A;
                else if (Op == OP_MTLO) mLo = A;
                else if ((Op == OP_MADD || Op == OP_MSUB) && !MADD_EN) mLeft = 0;
                else begin
                    {pDz, pHi, pLo} = modelOp(Op, A, B, mHi, mLo);
                    mLeft = 33;
                end
            end
        end
    end

    // Compare every output against the model once per cycle.
    always @(negedge Clk) begin
        if (checkEn) begin
            check("HI", 64'(HI), 64'(mHi));
            check("LO", 64'(LO), 64'(mLo));
            check("Busy", 64'(Busy), 64'(mLeft > 0));
            check("Done", 64'(Done), 64'(mDone));
            check("DivZero", 64'(DivZero), 64'(mDz));
            check("Stall", 64'(Stall), 64'((mLeft > 0) && (Start || ReadHiLo)));
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Op = op; A = a; B = b; Start = 1'b1;
        @(posedge Clk);
        #2;
        Start = 1'b0;
    endtask

    task automatic waitDone(output int n, output logic dz);
        n = -1; dz = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge Clk);
            #1;
            if (Done) begin
                n = i; dz = DivZero;
                break;
            end
        end
        #1;
    endtask

    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a, b,
                         input logic [31:0] expHi, expLo, input logic expDz);
        int n;
        logic dz;
        issue(op, a, b);
        waitDone(n, dz);
        check({name, "_lat"}, 64'(n), 64'd33);
        check({name, "_hi"}, 64'(HI), 64'(expHi));
        check({name, "_lo"}, 64'(LO), 64'(expLo));
        check({name, "_dz"}, 64'(dz), 64'(expDz));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic dz, stallHigh, doneSeen;

        #13;
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'({Done, DivZero}), 64'd0);
        checkEn = 1'b1;
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        Op = OP_MTLO; A = 32'd5; Start = 1'b1;
        @(posedge Clk);
        #2;
        Start = 1'b0;
        check("first_accept_lo", 64'(LO), 64'd5);
        check("mtlo_busy", 64'(Busy), 64'd0);

        runOp("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        runOp("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        runOp("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        runOp("div_zero", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        runOp("divu_zero", OP_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
        runOp("div_rem", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);

        // Held Start/ReadHiLo during a divide: stalled until the Done cycle.
        issue(OP_DIVU, 32'd1000, 32'd10);
        Op = OP_MULTU; A = 32'd3; B = 32'd5; Start = 1'b1; ReadHiLo = 1'b1;
        stallHigh = 1'b1; n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge Clk);
            #1;
            if (Done) begin
                n = i;
                break;
            end else begin
                stallHigh = stallHigh & Stall;
            end
        end
        check("stall_lat", 64'(n), 64'd33);
        check("stall_busy", 64'(stallHigh), 64'd1);
        check("stall_done", 64'(Stall), 64'd0);
        check("stall_read_hi", 64'(HI), 64'd0);
        check("stall_read_lo", 64'(LO), 64'd100);
        @(posedge Clk);
        #2;
        Start = 1'b0; ReadHiLo = 1'b0;
        check("second_accepted", 64'(Busy), 64'd1);
        waitDone(n, dz);
        check("second_lat", 64'(n), 64'd33);
        check("second_lo", 64'(LO), 64'd15);
        check("second_hi", 64'(HI), 64'd0);

        // Flush mid-iteration, then Flush+Start together in IDLE.
        issue(OP_MTHI, 32'hAAAA, 32'd0);
        issue(OP_MTLO, 32'h5555, 32'd0);
        issue(OP_MULT, 32'd123, 32'd456);
        repeat (10) @(posedge Clk);
        #2;
        Flush = 1'b1;
        @(posedge Clk);
        #1;
        check("flush_idle", 64'(Busy), 64'd0);
        #1;
        Flush = 1'b0;
        doneSeen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1;
            doneSeen = doneSeen | Done;
        end
        #1;
        check("flush_no_done", 64'(doneSeen), 64'd0);
        check("flush_hilo", {HI, LO}, {32'hAAAA, 32'h5555});
        Flush = 1'b1;
        issue(OP_MTHI, 32'hBEEF, 32'd0);
        Flush = 1'b0;
        check("flush_prio", 64'(HI), 64'hAAAA);

        // Reset asserted between edges during a divide.
        issue(OP_DIVU, 32'd50, 32'd3);
        repeat (20) @(posedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        check("midrst_hilo", {HI, LO}, 64'd0);
        check("midrst_busy", 64'({Busy, Done, DivZero}), 64'd0);
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        @(posedge Clk);
        #2;

`ifdef MULDIV_MADD_EN
        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'd5, 32'd0);
        runOp("madd", OP_MADD, 32'd2, 32'd3, 32'd0, 32'd11, 1'b0);
        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'd5, 32'd0);
        runOp("msub", OP_MSUB, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`else
        issue(OP_MTHI, 32'h11, 32'd0);
        issue(OP_MTLO, 32'h22, 32'd0);
        issue(OP_MADD, 32'd2, 32'd3);
        check("madd_nop_busy", 64'(Busy), 64'd0);
        issue(OP_MSUB, 32'd2, 32'd3);
        check("msub_nop_busy", 64'(Busy), 64'd0);
        repeat (3) @(posedge Clk);
        #2;
        check("maddsub_nop_hilo", {HI, LO}, {32'h11, 32'h22});
`endif

        // A few arbitrary operands, checked by the model every cycle.
        for (int k = 0; k < 6; k++) begin
            issue(3'($urandom_range(0, 3)), $urandom(), (k == 3) ? 32'd0 : $urandom());
            waitDone(n, dz);
            check("rand_lat", 64'(n), 64'd33);
        end

        repeat (2) @(posedge Clk);
        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
